// File: rtl/estimador_func_matvec_mac.sv
// estimador_func_matvec_mac
// Sequential 3x3 matrix by 3-vector fixed-point multiply-accumulate for the
// estimator datapath. One shared signed multiplier evaluates one product per
// cycle (row i, column j, j innermost). Each finished row is shifted by FRAC_W
// (floor), saturated to DATA_W bits and registered on y_V_<r>_out.
// Ports:
//   ap_clk, ap_rst               clock, async active-high reset
//   ap_start/done/idle/ready     block-level handshake
//   a_V_<r>_<c>_reload           signed matrix elements
//   x_V_<c>_reload               signed vector elements
//   y_V_<r>_out[_ap_vld]         registered results and their one-cycle strobes
module estimador_func_matvec_mac #(
  parameter int DATA_W = 21,
  parameter int FRAC_W = 14
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] a_V_0_0_reload,
  input  logic [DATA_W-1:0] a_V_0_1_reload,
  input  logic [DATA_W-1:0] a_V_0_2_reload,
  input  logic [DATA_W-1:0] a_V_1_0_reload,
  input  logic [DATA_W-1:0] a_V_1_1_reload,
  input  logic [DATA_W-1:0] a_V_1_2_reload,
  input  logic [DATA_W-1:0] a_V_2_0_reload,
  input  logic [DATA_W-1:0] a_V_2_1_reload,
  input  logic [DATA_W-1:0] a_V_2_2_reload,
  input  logic [DATA_W-1:0] x_V_0_reload,
  input  logic [DATA_W-1:0] x_V_1_reload,
  input  logic [DATA_W-1:0] x_V_2_reload,
  output logic [DATA_W-1:0] y_V_0_out,
  output logic              y_V_0_out_ap_vld,
  output logic [DATA_W-1:0] y_V_1_out,
  output logic              y_V_1_out_ap_vld,
  output logic [DATA_W-1:0] y_V_2_out,
  output logic              y_V_2_out_ap_vld
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_MAC  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_a [3][3];
  logic [DATA_W-1:0] r_x [3];
  logic [DATA_W-1:0] r_y [3];
  logic [DATA_W-1:0] w_a_in [3][3];
  logic [DATA_W-1:0] w_x_in [3];
  logic signed [ACC_W-1:0]  r_acc;
  logic [1:0]               r_i, r_j;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum, w_shr;
  logic [DATA_W-1:0]        w_sat;
  logic                     w_last;

  assign w_a_in[0][0] = a_V_0_0_reload;
  assign w_a_in[0][1] = a_V_0_1_reload;
  assign w_a_in[0][2] = a_V_0_2_reload;
  assign w_a_in[1][0] = a_V_1_0_reload;
  assign w_a_in[1][1] = a_V_1_1_reload;
  assign w_a_in[1][2] = a_V_1_2_reload;
  assign w_a_in[2][0] = a_V_2_0_reload;
  assign w_a_in[2][1] = a_V_2_1_reload;
  assign w_a_in[2][2] = a_V_2_2_reload;
  assign w_x_in[0]    = x_V_0_reload;
  assign w_x_in[1]    = x_V_1_reload;
  assign w_x_in[2]    = x_V_2_reload;

  // Shared multiplier feeding straight into the accumulate/round/saturate path.
  assign w_prod = $signed(r_a[r_i][r_j]) * $signed(r_x[r_j]);
  assign w_sum  = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  // Arithmetic shift floors toward -inf, so -1/2^FRAC_W becomes -1, not 0.
  assign w_shr  = w_sum >>> FRAC_W;
  assign w_last = (r_i == 2'd2) && (r_j == 2'd2);

  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
    else if (w_shr < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ap_start) w_next = S_MAC;
      S_MAC:   if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      for (int r = 0; r < 3; r++) begin
        r_x[r] <= '0;
        r_y[r] <= '0;
        for (int c = 0; c < 3; c++) r_a[r][c] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (ap_start) begin
          r_a   <= w_a_in;
          r_x   <= w_x_in;
          r_acc <= '0;
          r_i   <= '0;
          r_j   <= '0;
        end
        S_MAC: begin
          if (r_j == 2'd2) begin
            r_y[r_i] <= w_sat;
            r_acc    <= '0;
            r_j      <= '0;
            r_i      <= (r_i == 2'd2) ? 2'd0 : r_i + 2'd1;
          end else begin
            r_acc <= w_sum;
            r_j   <= r_j + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_idle          = (r_state == S_IDLE);
  assign ap_done          = (r_state == S_DONE);
  assign ap_ready         = ap_done;
  assign y_V_0_out_ap_vld = ap_done;
  assign y_V_1_out_ap_vld = ap_done;
  assign y_V_2_out_ap_vld = ap_done;
  assign y_V_0_out        = r_y[0];
  assign y_V_1_out        = r_y[1];
  assign y_V_2_out        = r_y[2];

endmodule

// File: tb/tb_estimador_func_matvec_mac.sv
module tb_estimador_func_matvec_mac;
  localparam int DW = 21;
  localparam int ONE = 16384;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ap_start = 1'b0;
  logic ap_done, ap_idle, ap_ready;
  logic signed [DW-1:0] a [3][3];
  logic signed [DW-1:0] x [3];
  logic [DW-1:0] y0, y1, y2;
  logic v0, v1, v2;

  always #5 ap_clk = ~ap_clk;

  estimador_func_matvec_mac #(.DATA_W(DW), .FRAC_W(14)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .a_V_0_0_reload(a[0][0]), .a_V_0_1_reload(a[0][1]), .a_V_0_2_reload(a[0][2]),
    .a_V_1_0_reload(a[1][0]), .a_V_1_1_reload(a[1][1]), .a_V_1_2_reload(a[1][2]),
    .a_V_2_0_reload(a[2][0]), .a_V_2_1_reload(a[2][1]), .a_V_2_2_reload(a[2][2]),
    .x_V_0_reload(x[0]), .x_V_1_reload(x[1]), .x_V_2_reload(x[2]),
    .y_V_0_out(y0), .y_V_0_out_ap_vld(v0),
    .y_V_1_out(y1), .y_V_1_out_ap_vld(v1),
    .y_V_2_out(y2), .y_V_2_out_ap_vld(v2)
  );

  typedef struct {
    logic signed [DW-1:0] e0, e1, e2;
    int cyc;
    string name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [DW-1:0] act, input logic signed [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: strobes must track ap_done; each done pops one expectation.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      checks++;
      if ({v0, v1, v2, ap_ready} !== {4{ap_done}}) begin
        errors++;
        $display("FAIL strobes cyc=%0d actual vld=%b%b%b ready=%b required=%b", cyc, v0, v1, v2, ap_ready, ap_done);
      end
      if (ap_done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done cyc=%0d actual=done required=no done", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_cycle"}, DW'(cyc), DW'(e.cyc));
          chk({e.name, "_y0"}, y0, e.e0);
          chk({e.name, "_y1"}, y1, e.e1);
          chk({e.name, "_y2"}, y2, e.e2);
        end
      end
    end
  end

  task automatic set_a(input int d0, input int d1, input int d2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) a[r][c] = '0;
    a[0][0] = DW'(d0); a[1][1] = DW'(d1); a[2][2] = DW'(d2);
  endtask

  task automatic set_x(input int v0i, input int v1i, input int v2i);
    x[0] = DW'(v0i); x[1] = DW'(v1i); x[2] = DW'(v2i);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge ap_clk);
    while (!ap_idle && n < 30) begin @(negedge ap_clk); n++; end
    if (!ap_idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 40) begin @(posedge ap_clk); n++; end
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=pending %0d required=0", nm, q.size());
      q.delete();
    end
  endtask

  // Issue one start pulse (caller is just after a posedge while idle).
  task automatic run(input string nm, input int e0, input int e1, input int e2);
    exp_t e;
    e.e0 = DW'(e0); e.e1 = DW'(e1); e.e2 = DW'(e2); e.cyc = cyc + 10; e.name = nm;
    q.push_back(e);
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    drain(nm);
  endtask

  initial begin
    exp_t e;
    int base;
    set_a(0, 0, 0); set_x(0, 0, 0);
    #12;
    chk("rst_y0", y0, 0); chk("rst_y1", y1, 0); chk("rst_y2", y2, 0);
    chk("rst_idle", DW'(ap_idle), 1); chk("rst_done", DW'(ap_done), 0);
    ap_rst = 1'b0;
    wait_idle();

    set_a(ONE, ONE, ONE); set_x(100, -200, 300);
    run("identity", 100, -200, 300);

    wait_idle();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) a[r][c] = 21'sd1048575;
    set_x(1048575, 1048575, 1048575);
    run("pos_sat", 1048575, 1048575, 1048575);

    wait_idle();
    set_a(-1048576, 0, 0); set_x(1048575, 0, 0);
    run("neg_sat", -1048576, 0, 0);

    wait_idle();
    set_a(1, 0, 0); set_x(-1, 0, 0);
    run("trunc_neg", -1, 0, 0);

    wait_idle();
    set_a(1, 0, 0); set_x(1, 0, 0);
    run("trunc_pos", 0, 0, 0);

    // Mixed rows: 3000, floor(-7000/16384) = -1, -1000.
    wait_idle();
    a[0][0] = DW'(ONE); a[0][1] = DW'(8192); a[0][2] = DW'(-4096);
    a[1][0] = DW'(1);   a[1][1] = DW'(2);    a[1][2] = DW'(3);
    a[2][0] = DW'(-ONE); a[2][1] = '0;       a[2][2] = '0;
    set_x(1000, 2000, -4000);
    run("mixed", 3000, -1, -1000);

    // Back-to-back with start held; x changes mid-run 1.
    wait_idle();
    set_a(ONE, ONE, ONE); set_x(100, -200, 300);
    base = cyc;
    e.e0 = DW'(100); e.e1 = DW'(-200); e.e2 = DW'(300); e.cyc = base + 10; e.name = "b2b_run1";
    q.push_back(e);
    e.e0 = DW'(5); e.e1 = DW'(5); e.e2 = DW'(5); e.cyc = base + 21; e.name = "b2b_run2";
    q.push_back(e);
    ap_start = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1 set_x(5, 5, 5);
    repeat (8) @(posedge ap_clk);
    #1 ap_start = 1'b0;
    drain("b2b");

    // Reset mid-run: no expectation pushed, so any done is flagged.
    wait_idle();
    set_x(7, 8, 9);
    ap_start = 1'b1;
    @(posedge ap_clk); #1 ap_start = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    #1;
    chk("midrst_y0", y0, 0); chk("midrst_y1", y1, 0); chk("midrst_y2", y2, 0);
    chk("midrst_idle", DW'(ap_idle), 1); chk("midrst_done", DW'(ap_done), 0);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1;
    chk("midrst_no_done_q", DW'(q.size()), 0);
    wait_idle();
    set_a(ONE, ONE, ONE); set_x(100, -200, 300);
    run("after_rst", 100, -200, 300);

    repeat (3) @(posedge ap_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/estimador_func_matvec_mac.md
# estimador_func_matvec_mac

Sequential 3x3 matrix by 3-vector multiply-accumulate stage of the estimator datapath. It produces the fixed-point row vector that the saturating vector-add stage consumes as one of its addends (e.g. A·x̂ or L·(y−ŷ)). It uses one shared signed multiplier and an ap_start/ap_done/ap_idle/ap_ready block handshake. Results are presented on `*_out` ports with per-output `ap_vld` strobes.

## Interface
Parameters:
- DATA_W, 21: width of every signed fixed-point operand and result.
- FRAC_W, 14: fractional bits; 1.0 = 2^FRAC_W = 16384.

Ports:
- ap_clk  in  1  the single clock; all state updates on its rising edge.
- ap_rst  in  1  reset, asynchronous and active-high.
- ap_start  in  1  start request, sampled in IDLE.
- ap_done  out  1  one-cycle pulse when all three results are final.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done.
- a_V_r_c_reload (r,c ∈ 0..2)  in  DATA_W each  matrix element row r, column c; signed.
- x_V_c_reload (c ∈ 0..2)  in  DATA_W each  vector element c; signed.
- y_V_r_out (r ∈ 0..2)  out  DATA_W each  result row r; signed, registered.
- y_V_r_out_ap_vld (r ∈ 0..2)  out  1 each  high for one cycle with ap_done.

## Operation
- Operation: y_r = sat( floor( Σ_c a_rc·x_c / 2^FRAC_W ) ).
- States: IDLE, MAC, DONE; one-hot encoded.
- IDLE:
  - ap_idle=1.
  - On ap_start=1, latch all 12 inputs into operand registers, clear accumulator, set i=0, j=0, go to MAC.
  - Later input changes are ignored until the next start.
- MAC, one product per cycle, j inner loop:
  - prod = a[i][j]·x[j], signed 2·DATA_W = 42 bits.
  - acc is 44-bit signed; it cannot overflow because it holds at most 3 products.
  - j<2: acc += prod; j++.
  - j==2:
    - sum = acc + prod.
    - r = sum >>> FRAC_W (arithmetic shift = truncation toward −inf).
    - y_i register ← saturate(r) to [−2^(DATA_W−1), 2^(DATA_W−1)−1] = [−1048576, 1048575].
    - acc ← 0; j ← 0; i++.
  - After i=2, j=2, go to DONE.
- DONE:
  - ap_done=1, ap_ready=1, all three ap_vld=1 for exactly this cycle.
  - Next state is IDLE. ap_start is not sampled in DONE.
- Output hold:
  - y_V_r_out hold their value until overwritten in a later run.
  - During a run, y_0 and y_1 update mid-run. Consumers sample only on ap_vld.
- ap_idle=0 in MAC and DONE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, i=j=0, acc=0, operand regs=0, all y_V_r_out=0, ap_done=ap_ready=all ap_vld=0, ap_idle=1.
- Reset mid-run aborts the run with no done pulse. The first start after reset deasserts behaves normally.
- Cycle numbering:
  - start accepted at cycle 0 (IDLE edge);
  - MAC occupies cycles 1–9;
  - y_0 is written at end of cycle 3, y_1 at end of cycle 6, y_2 at end of cycle 9;
  - ap_done/ap_vld are high in cycle 10.
- Latency start→done: 10 cycles. Initiation interval: 11 cycles (IDLE in cycle 11 can accept the next start).
- ap_start held continuously high gives back-to-back runs with done pulses every 11 cycles.
- The multiplier is combinational into the acc/y registers. The critical path is 21x21 multiply + 44-bit add + saturate, which must meet the estimator clock.

## Test plan
- Identity: a_ii=16384, others 0; x=(100,−200,300); start -> ap_done high exactly 10 cycles after start, y=(100,−200,300), all three ap_vld high in that cycle only.
- Positive saturation: all a=1048575, all x=1048575 -> y=(1048575,1048575,1048575).
- Negative saturation: a_00=−1048576, x_0=1048575, others 0 -> y_0=−1048576, y_1=y_2=0.
- Truncation: a_00=1, x_0=−1, others 0 -> y_0=−1 (floor, not 0). a_00=1, x_0=1 -> y_0=0.
- Latching and back-to-back runs:
  - Hold ap_start high; run 1 uses the identity/x set above.
  - Change x to (5,5,5) during cycle 4 of run 1 -> run-1 results unchanged; done pulses at cycles 10 and 21; run-2 y=(5,5,5).
- Reset mid-run: assert ap_rst in cycle 5 of a run -> outputs 0 and ap_idle=1 immediately, no ap_done. Release and start again -> correct results 10 cycles after that start.
